// File: rtl/pu_result_writer_pkg.sv
// Shared definitions for the PU result path: default widths, FSM state encoding
// and the accumulator-to-result saturation helper.
package pu_result_writer_pkg;

  localparam int unsigned PU_MAC_NUM = 8;
  localparam int unsigned PU_DATA_W  = 16;
  localparam int unsigned PU_ACC_W   = 24;
  localparam int unsigned PU_OUT_W   = 16;
  localparam int unsigned PU_ROWS    = 8;
  localparam int unsigned PU_ADDR_W  = 3;

  // 2'b10 is unused and recovers to IDLE
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b11
  } state_e;

  localparam logic signed [PU_ACC_W-1:0] SAT_MAX = PU_ACC_W'(2 ** (PU_OUT_W - 1) - 1);
  localparam logic signed [PU_ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  // Clamp a signed accumulator value into the signed result range
  function automatic logic [PU_OUT_W-1:0] saturate(input logic signed [PU_ACC_W-1:0] v);
    if (v > SAT_MAX) begin
      return {1'b0, {(PU_OUT_W - 1){1'b1}}};
    end else if (v < SAT_MIN) begin
      return {1'b1, {(PU_OUT_W - 1){1'b0}}};
    end
    return v[PU_OUT_W-1:0];
  endfunction

endpackage

// File: rtl/pu_result_writer_if.sv
// PU handshake from the local controller / MAC array and the result-buffer write port.
interface pu_result_writer_if
  import pu_result_writer_pkg::*;
#(
  parameter int unsigned MAC_NUM = PU_MAC_NUM,
  parameter int unsigned DATA_W  = PU_DATA_W,
  parameter int unsigned OUT_W   = PU_OUT_W,
  parameter int unsigned ADDR_W  = PU_ADDR_W
);

  logic                      start_i;
  logic                      pu_valid_i;
  logic                      pu_clear_i;
  logic [MAC_NUM*DATA_W-1:0] pu_prod_i;
  logic [ADDR_W-1:0]         dout_addr_o;
  logic                      dout_we_o;
  logic [OUT_W-1:0]          dout_data_o;
  logic                      busy_o;
  logic                      done_o;

  modport master (
    output start_i, pu_valid_i, pu_clear_i, pu_prod_i,
    input  dout_addr_o, dout_we_o, dout_data_o, busy_o, done_o
  );

  modport slave (
    input  start_i, pu_valid_i, pu_clear_i, pu_prod_i,
    output dout_addr_o, dout_we_o, dout_data_o, busy_o, done_o
  );

endinterface

// File: rtl/pu_lane_adder_tree.sv
// Combinational signed sum of MAC_NUM lane products, sign-extended to ACC_W.
module pu_lane_adder_tree #(
  parameter int unsigned MAC_NUM = 8,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ACC_W   = 24
) (
  input  logic [MAC_NUM*DATA_W-1:0] i_prod,
  output logic signed [ACC_W-1:0]   o_sum_c
);

  always_comb begin
    o_sum_c = '0;
    for (int unsigned k = 0; k < MAC_NUM; k++) begin
      o_sum_c = o_sum_c + ACC_W'($signed(i_prod[k*DATA_W +: DATA_W]));
    end
  end

endmodule

// File: rtl/pu_result_writer.sv
// Accumulates per-cycle lane sums into dot products and writes one saturated
// result per pu_clear_i to the result buffer; pulses done_o after ROWS results.
module pu_result_writer
  import pu_result_writer_pkg::*;
#(
  parameter int unsigned MAC_NUM = PU_MAC_NUM,
  parameter int unsigned DATA_W  = PU_DATA_W,
  parameter int unsigned ACC_W   = PU_ACC_W,
  parameter int unsigned OUT_W   = PU_OUT_W,
  parameter int unsigned ROWS    = PU_ROWS,
  parameter int unsigned ADDR_W  = PU_ADDR_W
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  pu_result_writer_if.slave  bus
);

  state_e                    r_state;
  logic signed [ACC_W-1:0]   r_acc;
  logic [ADDR_W-1:0]         r_wr_cnt;
  logic [ADDR_W-1:0]         r_addr;
  logic                      r_we;
  logic [OUT_W-1:0]          r_data;
  logic                      r_busy;
  logic                      r_done;

  logic signed [ACC_W-1:0]   w_lane_sum;
  logic signed [ACC_W-1:0]   w_res;
  logic                      w_last;
  logic [ADDR_W-1:0]         w_wr_cnt_nxt;

  pu_lane_adder_tree #(
    .MAC_NUM (MAC_NUM),
    .DATA_W  (DATA_W),
    .ACC_W   (ACC_W)
  ) u_adder (
    .i_prod  (bus.pu_prod_i),
    .o_sum_c (w_lane_sum)
  );

  // A closing cycle still folds in its own lane sum when valid
  assign w_res        = r_acc + (bus.pu_valid_i ? w_lane_sum : ACC_W'(0));
  assign w_last       = (r_wr_cnt == ADDR_W'(ROWS - 1));
  assign w_wr_cnt_nxt = w_last ? '0 : r_wr_cnt + ADDR_W'(1);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state  <= IDLE;
      r_acc    <= '0;
      r_wr_cnt <= '0;
      r_addr   <= '0;
      r_we     <= 1'b0;
      r_data   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_acc <= '0;
          if (bus.start_i) begin
            r_state  <= RUN;
            r_wr_cnt <= '0;
            r_busy   <= 1'b1;
          end
        end
        RUN: begin
          if (bus.pu_clear_i) begin
            r_acc    <= '0;
            r_we     <= 1'b1;
            r_addr   <= r_wr_cnt;
            r_data   <= saturate(w_res);
            r_wr_cnt <= w_wr_cnt_nxt;
            if (w_last) begin
              r_state <= DONE;
            end
          end else if (bus.pu_valid_i) begin
            r_acc <= r_acc + w_lane_sum;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_acc   <= '0;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
          r_acc   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dout_addr_o = r_addr;
  assign bus.dout_we_o   = r_we;
  assign bus.dout_data_o = r_data;
  assign bus.busy_o      = r_busy;
  assign bus.done_o      = r_done;

endmodule
